// File: rtl/pinpad_pkg.sv
// Shared types and constants for the 4x4 pin-pad key-matrix emulator.
package pinpad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } emu_state_e;

    typedef struct packed {
        logic [1:0] row_idx;
        logic [1:0] col_idx;
    } key_code_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered write-ready; a write while not ready is dropped.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    always_comb begin
        push     = wr_valid && ready_q;
        pop      = rd_en && (count_q != '0);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ready_d  = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign wr_ready = ready_q;
    assign count    = count_q;

endmodule

// File: rtl/pinpad_emulator.sv
// 4x4 pin-pad emulator: queues keystrokes, then closes one matrix contact
// (with optional bounce) so the addressed row answers its column strobe.
module pinpad_emulator
    import pinpad_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES  = 2_500_000,
    parameter int unsigned GAP_CYCLES    = 2_500_000,
    parameter int unsigned BOUNCE_CYCLES = 250_000,
    parameter int unsigned TOGGLE_CYCLES = 12_500,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    input  logic                          bounce_en,
    output logic                          key_ready,
    input  logic [3:0]                    col_n,
    output logic [3:0]                    row_n,
    output logic                          busy,
    output logic                          key_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned MAX_CYC = max_u(max_u(PRESS_CYCLES, GAP_CYCLES),
                                            max_u(BOUNCE_CYCLES, TOGGLE_CYCLES));
    localparam int unsigned PW = $clog2(MAX_CYC) + 1;
    localparam int unsigned TW = $clog2(TOGGLE_CYCLES) + 1;

    // Counters reload with N-1 and expire at 0, so each phase spans N cycles.
    localparam logic [PW-1:0] PRESS_LD  = PW'(PRESS_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LD    = PW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] BOUNCE_LD = PW'(BOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TOG_LD    = TW'(TOGGLE_CYCLES - 1);

    emu_state_e    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] tog_q, tog_d;
    logic          contact_q, contact_d;
    logic [1:0]    cur_row_q, cur_row_d;
    logic [1:0]    cur_col_q, cur_col_d;
    logic          bnc_q, bnc_d;
    logic          busy_q, busy_d;
    logic          key_done_q, key_done_d;
    logic [3:0]    row_n_q, row_n_d;

    logic          fifo_pop;
    logic [3:0]    fifo_rd_data;
    key_code_t     fifo_key;

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (key_valid),
        .wr_ready (key_ready),
        .wr_data  (key_code),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign fifo_key = key_code_t'(fifo_rd_data);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tog_d      = tog_q;
        contact_d  = contact_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        bnc_d      = bnc_q;
        busy_d     = busy_q;
        key_done_d = 1'b0;
        fifo_pop   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Holding off in the key_done cycle keeps keys PRESS+GAP+2 apart.
                if ((fifo_count != '0) && !key_done_q) begin
                    fifo_pop  = 1'b1;
                    cur_row_d = fifo_key.row_idx;
                    cur_col_d = fifo_key.col_idx;
                    bnc_d     = bounce_en;
                    busy_d    = 1'b1;
                    contact_d = 1'b1;
                    tog_d     = TOG_LD;
                    state_d   = bounce_en ? BOUNCE_IN : HOLD;
                    phase_d   = bounce_en ? BOUNCE_LD : PRESS_LD;
                end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
                if (phase_q == '0) begin
                    state_d   = (state_q == BOUNCE_IN) ? HOLD : GAP;
                    phase_d   = (state_q == BOUNCE_IN) ? PRESS_LD : GAP_LD;
                    contact_d = (state_q == BOUNCE_IN);
                end else begin
                    phase_d = phase_q - PW'(1);
                    if (tog_q == '0) begin
                        tog_d     = TOG_LD;
                        contact_d = ~contact_q;
                    end else begin
                        tog_d = tog_q - TW'(1);
                    end
                end
            end
            HOLD: begin
                if (phase_q == '0) begin
                    state_d   = bnc_q ? BOUNCE_OUT : GAP;
                    phase_d   = bnc_q ? BOUNCE_LD : GAP_LD;
                    tog_d     = TOG_LD;
                    contact_d = 1'b0;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            GAP: begin
                if (phase_q == '0) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    key_done_d = 1'b1;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            row_n_d[r] = ~(contact_q && (cur_row_q == 2'(r)) && !col_n[cur_col_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            tog_q      <= '0;
            contact_q  <= 1'b0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            bnc_q      <= 1'b0;
            busy_q     <= 1'b0;
            key_done_q <= 1'b0;
            row_n_q    <= '1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tog_q      <= tog_d;
            contact_q  <= contact_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            bnc_q      <= bnc_d;
            busy_q     <= busy_d;
            key_done_q <= key_done_d;
            row_n_q    <= row_n_d;
        end
    end

    assign row_n    = row_n_q;
    assign busy     = busy_q;
    assign key_done = key_done_q;

endmodule

// File: tb/tb_pinpad_emulator.sv
// Directed bench for pinpad_emulator: a timeline model of each key (pop cycle
// plus phase arithmetic) is compared every cycle, with literal pins per scenario.
module tb_pinpad_emulator;

    localparam int P = 20;
    localparam int G = 10;
    localparam int B = 8;
    localparam int T = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       bounce_en;
    logic       key_ready;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic       busy;
    logic       key_done;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    pinpad_emulator #(
        .PRESS_CYCLES  (P),
        .GAP_CYCLES    (G),
        .BOUNCE_CYCLES (B),
        .TOGGLE_CYCLES (T),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .bounce_en  (bounce_en),
        .key_ready  (key_ready),
        .col_n      (col_n),
        .row_n      (row_n),
        .busy       (busy),
        .key_done   (key_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- timeline model ----------------
    logic [3:0] mq [$];
    bit         m_act, m_bnc, m_done, m_busy, m_ready, m_contact;
    int         m_pop_cyc;
    logic [3:0] m_code;
    int         m_count;
    logic [3:0] m_row;

    // Contact state 'rel' cycles after the pop cycle.
    function automatic bit contact_at(input int rel, input bit b);
        if (b) begin
            if (rel >= 1 && rel <= B)               return ((rel - 1) / T) % 2 == 0;
            if (rel > B && rel <= B + P)            return 1'b1;
            if (rel > B + P && rel <= 2 * B + P)    return ((rel - B - P - 1) / T) % 2 == 1;
            return 1'b0;
        end
        return rel >= 1 && rel <= P;
    endfunction

    // Cycles from pop cycle to key_done cycle, both inclusive.
    function automatic int key_len(input bit b);
        return P + G + 2 + (b ? 2 * B : 0);
    endfunction

    always @(posedge clk) begin
        bit pop, push;
        cyc++;
        if (reset) begin
            mq.delete();
            m_act = 0; m_done = 0; m_busy = 0; m_contact = 0;
            m_count = 0; m_ready = 1; m_row = 4'hF;
        end else begin
            m_row = 4'hF;
            if (m_contact && !col_n[m_code[1:0]]) m_row[m_code[3:2]] = 1'b0;
            pop  = !m_act && (m_count > 0) && !m_done;
            push = key_valid && m_ready;
            m_done = m_act && (cyc == m_pop_cyc + key_len(m_bnc) - 1);
            if (m_done) m_act = 0;
            if (pop) begin
                m_act = 1;
                m_pop_cyc = cyc - 1;
                m_code = mq.pop_front();
                m_bnc = bounce_en;
            end
            if (push) mq.push_back(key_code);
            m_count   = mq.size();
            m_ready   = m_count < DEPTH;
            m_busy    = m_act;
            m_contact = m_act && contact_at(cyc - m_pop_cyc, m_bnc);
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("row_n",      row_n,      m_row);
            check("key_ready",  key_ready,  m_ready);
            check("busy",       busy,       m_busy);
            check("key_done",   key_done,   m_done);
            check("fifo_count", fifo_count, m_count);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_key(input logic [3:0] code, input bit bnc, input bit walk,
                           output int lows, output int falls, output int stray, output int dt);
        int p, r;
        bit prev;
        logic [3:0] one;
        one = 4'b0001;
        r = int'(code[3:2]);
        lows = 0; falls = 0; stray = 0; dt = -1; prev = 1'b1;
        key_code = code; bounce_en = bnc; key_valid = 1'b1; p = cyc;
        for (int i = 0; i < 200 && dt < 0; i++) begin
            if (walk) col_n = ~(one << (i % 4));
            @(negedge clk);
            key_valid = 1'b0;
            if (row_n[r] == 1'b0) begin
                lows++;
                if (prev) falls++;
            end
            prev = row_n[r];
            for (int j = 0; j < 4; j++) if (j != r && row_n[j] == 1'b0) stray++;
            if (key_done === 1'b1) dt = cyc - p;
        end
        bounce_en = 1'b0;
    endtask

    logic [3:0] batch [5] = '{4'h5, 4'hA, 4'hF, 4'h4, 4'h8};
    int         done_at [8];

    initial begin
        int lows, falls, stray, dt, nd, d, dn;
        bit seen;
        reset = 1'b1; key_valid = 1'b0; key_code = '0; bounce_en = 1'b0; col_n = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_row_n",  row_n,      4'hF);
        check("rst_ready",  key_ready,  1);
        check("rst_busy",   busy,       0);
        check("rst_count",  fifo_count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Row 1, col 2, scanner holding column 2 low.
        col_n = 4'b1011;
        run_key(4'b0110, 1'b0, 1'b0, lows, falls, stray, dt);
        check("t1_low_cycles", lows, 20);
        check("t1_falls", falls, 1);
        check("t1_stray", stray, 0);
        check("t1_done_dt", dt, 32);
        @(negedge clk);

        // Same key, scanner walking one column per cycle.
        run_key(4'b0110, 1'b0, 1'b1, lows, falls, stray, dt);
        check("t2_low_cycles", lows, 5);
        check("t2_falls", falls, 5);
        check("t2_stray", stray, 0);
        check("t2_done_dt", dt, 32);
        col_n = 4'hF;
        @(negedge clk);

        // Bounce: 2 low pulses in, 20 held, 2 low pulses out.
        col_n = 4'b1110;
        run_key(4'b0000, 1'b1, 1'b0, lows, falls, stray, dt);
        check("t3_low_cycles", lows, 28);
        check("t3_falls", falls, 5);
        check("t3_stray", stray, 0);
        check("t3_done_dt", dt, 48);
        @(negedge clk);

        // Queue fills behind a key in progress; 5th push dropped.
        col_n = 4'h0;
        key_code = 4'h0; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            key_code = batch[i]; key_valid = 1'b1;
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("full_count", fifo_count, 4);
        check("full_ready", key_ready, 0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (key_done === 1'b1) seen = 1'b1;
        end
        check("primer_done_seen", seen, 1);
        d = cyc;
        @(negedge clk);
        check("pop_cycle_count", fifo_count, 4);
        key_code = 4'hC; key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("push_at_pop_count", fifo_count, 3);
        check("push_at_pop_ready", key_ready, 1);
        nd = 0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            if (key_done === 1'b1) begin
                if (nd < 8) done_at[nd] = cyc;
                nd++;
            end
        end
        check("batch_done_pulses", nd, 4);
        if (nd >= 4) begin
            check("batch_gap0", done_at[0] - d, 32);
            for (int k = 1; k < 4; k++) check("batch_gap", done_at[k] - done_at[k-1], 32);
        end

        // Reset in the middle of HOLD with one key still queued.
        key_code = 4'b1001; key_valid = 1'b1;
        @(negedge clk);
        key_code = 4'b0010;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_row_n", row_n, 4'b1011);
        check("hold_count", fifo_count, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_row_n", row_n, 4'hF);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_done === 1'b1) dn++;
        end
        check("midrst_no_done", dn, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
